// File: rtl/mvu_8sx8u_mac_pkg.sv
// Shared types and constants for the MVU compute core.
package mvu_pkg;

  // Register stages from input capture to result: capture, dot product, accumulate.
  localparam int unsigned PIPELINE_DEPTH = 3;

  // Per-beat control travelling alongside the data through the pipeline.
  typedef struct packed {
    logic vld;
    logic lst;
  } stage_flags_t;

  // A zero beat is invalid and its last flag is dropped.
  function automatic stage_flags_t beat_flags(input logic last, input logic zero);
    stage_flags_t f;
    f.vld = ~zero;
    f.lst = last & ~zero;
    return f;
  endfunction

endpackage

// File: rtl/mvu_8sx8u_mac_lane.sv
// One PE lane: SIMD-wide signed dot product (S2) and accumulator/result (S3).
module mvu_lane #(
  parameter int unsigned SIMD               = 1,
  parameter int unsigned ACTIVATION_WIDTH   = 8,
  parameter int unsigned WEIGHT_WIDTH       = 8,
  parameter int unsigned ACCU_WIDTH         = 24,
  parameter int unsigned SIGNED_ACTIVATIONS = 0,
  parameter int unsigned FORCE_BEHAVIORAL   = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [SIMD*WEIGHT_WIDTH-1:0]     w,
  input  logic [SIMD*ACTIVATION_WIDTH-1:0] a,
  input  logic                             beat_vld,
  input  logic                             beat_lst,
  output logic [ACCU_WIDTH-1:0]            p
);

  localparam int unsigned WW = WEIGHT_WIDTH;
  localparam int unsigned AW = ACTIVATION_WIDTH;
  // Exact product of a WW-bit signed weight and an (AW+1)-bit signed activation.
  localparam int unsigned PW = WW + AW + 1;
  localparam int unsigned SW = (ACCU_WIDTH > PW) ? ACCU_WIDTH : PW;

  // Activations are widened by one bit so unsigned and signed share one signed multiply.
  function automatic logic [ACCU_WIDTH-1:0] dot(
    input logic [SIMD*WW-1:0] wv,
    input logic [SIMD*AW-1:0] av
  );
    logic signed [WW-1:0] we;
    logic        [AW-1:0] araw;
    logic signed [AW:0]   ae;
    logic signed [PW-1:0] prod;
    logic signed [SW-1:0] sum;
    sum = '0;
    for (int unsigned s = 0; s < SIMD; s++) begin
      we   = wv[s*WW +: WW];
      araw = av[s*AW +: AW];
      ae   = {(SIGNED_ACTIVATIONS != 0) & araw[AW-1], araw};
      prod = PW'(we) * PW'(ae);
      sum  = sum + SW'(prod);
    end
    return sum[ACCU_WIDTH-1:0];
  endfunction

  logic [ACCU_WIDTH-1:0] dot_nxt;
  logic [ACCU_WIDTH-1:0] d;
  logic [ACCU_WIDTH-1:0] acc;
  logic [ACCU_WIDTH-1:0] p_r;

  // Same arithmetic in both branches; only the mapping hint differs.
  if (FORCE_BEHAVIORAL != 0) begin : g_fabric
    (* use_dsp = "no" *) logic [ACCU_WIDTH-1:0] dot_w;
    assign dot_w   = dot(w, a);
    assign dot_nxt = dot_w;
  end else begin : g_dsp
    (* use_dsp = "yes" *) logic [ACCU_WIDTH-1:0] dot_w;
    assign dot_w   = dot(w, a);
    assign dot_nxt = dot_w;
  end

  // S2: register the lane's dot product for the beat held in S1.
  always_ff @(posedge clk) begin
    if (rst) begin
      d <= '0;
    end else if (en) begin
      d <= dot_nxt;
    end
  end

  // S3: accumulate valid beats; a last beat publishes the total and restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      p_r <= '0;
    end else if (en && beat_vld) begin
      if (beat_lst) begin
        p_r <= acc + d;
        acc <= '0;
      end else begin
        acc <= acc + d;
      end
    end
  end

  assign p = p_r;

endmodule

// File: rtl/mvu_8sx8u_mac.sv
// MVU compute core: PE lanes of SIMD-wide dot products with per-lane accumulation.
module mvu_8sx8u_mac
  import mvu_pkg::*;
#(
  parameter int unsigned PE                 = 1,
  parameter int unsigned SIMD               = 1,
  parameter int unsigned ACTIVATION_WIDTH   = 8,
  parameter int unsigned WEIGHT_WIDTH       = 8,
  parameter int unsigned ACCU_WIDTH         = 24,
  parameter int unsigned SIGNED_ACTIVATIONS = 0,
  parameter int unsigned FORCE_BEHAVIORAL   = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                last,
  input  logic                                zero,
  input  logic [PE*SIMD*WEIGHT_WIDTH-1:0]     w,
  input  logic [SIMD*ACTIVATION_WIDTH-1:0]    a,
  output logic                                vld,
  output logic [PE*ACCU_WIDTH-1:0]            p
);

  typedef logic [PE-1:0][SIMD-1:0][WEIGHT_WIDTH-1:0] w_vec_t;
  typedef logic [SIMD-1:0][ACTIVATION_WIDTH-1:0]     a_vec_t;
  typedef logic [PE-1:0][ACCU_WIDTH-1:0]             p_vec_t;

  localparam int unsigned LAST_STG = PIPELINE_DEPTH - 2;

  w_vec_t       w_s1;
  a_vec_t       a_s1;
  p_vec_t       p_lane;
  stage_flags_t stg [PIPELINE_DEPTH-1];
  logic         vld_r;

  // S1: capture operands of every enabled beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_s1 <= '0;
      a_s1 <= '0;
    end else if (en) begin
      w_s1 <= w;
      a_s1 <= a;
    end
  end

  // Shared valid/last flags for S1..S2, and the result strobe in S3.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < PIPELINE_DEPTH - 1; i++) begin
        stg[i] <= '0;
      end
      vld_r <= 1'b0;
    end else if (en) begin
      stg[0] <= beat_flags(last, zero);
      for (int unsigned i = 1; i < PIPELINE_DEPTH - 1; i++) begin
        stg[i] <= stg[i-1];
      end
      vld_r <= stg[LAST_STG].vld & stg[LAST_STG].lst;
    end
  end

  for (genvar pe = 0; pe < PE; pe++) begin : g_lane
    mvu_lane #(
      .SIMD               (SIMD),
      .ACTIVATION_WIDTH   (ACTIVATION_WIDTH),
      .WEIGHT_WIDTH       (WEIGHT_WIDTH),
      .ACCU_WIDTH         (ACCU_WIDTH),
      .SIGNED_ACTIVATIONS (SIGNED_ACTIVATIONS),
      .FORCE_BEHAVIORAL   (FORCE_BEHAVIORAL)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .w        (w_s1[pe]),
      .a        (a_s1),
      .beat_vld (stg[LAST_STG].vld),
      .beat_lst (stg[LAST_STG].lst),
      .p        (p_lane[pe])
    );
  end

  assign vld = vld_r;
  assign p   = p_lane;

endmodule

// File: tb/tb_mvu_8sx8u_mac.sv
// Bench for mvu_8sx8u_mac: three configurations share one stimulus stream.
module tb_mvu_8sx8u_mac;

  logic        clk;
  logic        rst;
  logic        en;
  logic        last;
  logic        zero;
  logic [31:0] w;
  logic [15:0] a;

  logic        vld_a, vld_b, vld_c;
  logic [47:0] p_a, p_b;
  logic [15:0] p_c;

  int total = 0;
  int bad   = 0;
  int ecount = 0;

  typedef struct packed {
    int              due;
    logic [1:0][23:0] pa;
    logic [1:0][23:0] pb;
    logic [1:0][7:0]  pc;
  } exp_t;

  exp_t   sb[$];
  exp_t   hold;
  logic   exp_vld;
  longint acc_u [2];
  longint acc_s [2];

  mvu_8sx8u_mac #(
    .PE(2), .SIMD(2), .ACTIVATION_WIDTH(8), .WEIGHT_WIDTH(8),
    .ACCU_WIDTH(24), .SIGNED_ACTIVATIONS(0), .FORCE_BEHAVIORAL(0)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .last(last), .zero(zero),
    .w(w), .a(a), .vld(vld_a), .p(p_a)
  );

  mvu_8sx8u_mac #(
    .PE(2), .SIMD(2), .ACTIVATION_WIDTH(8), .WEIGHT_WIDTH(8),
    .ACCU_WIDTH(24), .SIGNED_ACTIVATIONS(1), .FORCE_BEHAVIORAL(1)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .last(last), .zero(zero),
    .w(w), .a(a), .vld(vld_b), .p(p_b)
  );

  mvu_8sx8u_mac #(
    .PE(2), .SIMD(2), .ACTIVATION_WIDTH(8), .WEIGHT_WIDTH(8),
    .ACCU_WIDTH(8), .SIGNED_ACTIVATIONS(0), .FORCE_BEHAVIORAL(0)
  ) dut_c (
    .clk(clk), .rst(rst), .en(en), .last(last), .zero(zero),
    .w(w), .a(a), .vld(vld_c), .p(p_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference dot product for lane pe, exact in 64 bits.
  function automatic longint mdot(input int pe, input bit sgn,
                                  input logic [31:0] wv, input logic [15:0] av);
    longint s;
    longint wi;
    longint ai;
    s = 0;
    for (int i = 0; i < 2; i++) begin
      wi = longint'($signed(wv[(pe*2+i)*8 +: 8]));
      if (sgn) ai = longint'($signed(av[i*8 +: 8]));
      else     ai = longint'(av[i*8 +: 8]);
      s += wi * ai;
    end
    return s;
  endfunction

  function automatic logic [31:0] wp(input logic [7:0] w00, input logic [7:0] w01,
                                     input logic [7:0] w10, input logic [7:0] w11);
    return {w11, w10, w01, w00};
  endfunction

  function automatic logic [15:0] ap(input logic [7:0] a0, input logic [7:0] a1);
    return {a1, a0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: update the model at the edge, then compare outputs 1ns later.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    if (rst) begin
      for (int pe = 0; pe < 2; pe++) begin
        acc_u[pe] = 0;
        acc_s[pe] = 0;
      end
      sb.delete();
    end else if (en) begin
      ecount++;
      if (!zero) begin
        for (int pe = 0; pe < 2; pe++) begin
          acc_u[pe] += mdot(pe, 1'b0, w, a);
          acc_s[pe] += mdot(pe, 1'b1, w, a);
        end
        if (last) begin
          e.due = ecount + 2;
          for (int pe = 0; pe < 2; pe++) begin
            e.pa[pe] = acc_u[pe][23:0];
            e.pb[pe] = acc_s[pe][23:0];
            e.pc[pe] = acc_u[pe][7:0];
            acc_u[pe] = 0;
            acc_s[pe] = 0;
          end
          sb.push_back(e);
        end
      end
    end
    #1;
    if (rst) begin
      exp_vld = 1'b0;
      hold    = '0;
    end else if (en) begin
      if (sb.size() > 0 && sb[0].due == ecount) begin
        hold    = sb.pop_front();
        exp_vld = 1'b1;
      end else begin
        exp_vld = 1'b0;
      end
    end
    chk("vld_a", 32'(vld_a), 32'(exp_vld));
    chk("vld_b", 32'(vld_b), 32'(exp_vld));
    chk("vld_c", 32'(vld_c), 32'(exp_vld));
    for (int pe = 0; pe < 2; pe++) begin
      chk($sformatf("p_a[%0d]", pe), 32'(p_a[pe*24 +: 24]), 32'(hold.pa[pe]));
      chk($sformatf("p_b[%0d]", pe), 32'(p_b[pe*24 +: 24]), 32'(hold.pb[pe]));
      chk($sformatf("p_c[%0d]", pe), 32'(p_c[pe*8 +: 8]),   32'(hold.pc[pe]));
    end
  endtask

  task automatic beat(input logic [31:0] wv, input logic [15:0] av,
                      input logic l, input logic z);
    rst = 1'b0; en = 1'b1; w = wv; a = av; last = l; zero = z;
    tick();
  endtask

  // Enabled zero beats with random payload and random last, which must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      beat($urandom, 16'($urandom), 1'($urandom), 1'b1);
    end
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      rst = 1'b0; en = 1'b0;
      w = $urandom; a = 16'($urandom); last = 1'($urandom); zero = 1'($urandom);
      tick();
    end
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      rst = 1'b1; en = 1'b1;
      w = $urandom; a = 16'($urandom); last = 1'($urandom); zero = 1'($urandom);
      tick();
    end
    rst = 1'b0;
  endtask

  logic [31:0] ones_w;
  logic [15:0] ones_a;

  initial begin
    exp_vld = 1'b0;
    hold    = '0;
    ones_w  = wp(8'd1, 8'd1, 8'd1, 8'd1);
    ones_a  = ap(8'd1, 8'd1);
    rst = 1'b1; en = 1'b1; last = 1'b0; zero = 1'b0; w = '0; a = '0;

    // Power-on reset with random inputs.
    reset_cycles(2);

    // Partial sums in flight are discarded by a mid-stream reset.
    beat(ones_w, ones_a, 1'b0, 1'b0);
    beat(ones_w, ones_a, 1'b0, 1'b0);
    reset_cycles(2);

    // Single last beat, mixed-sign weights.
    beat(wp(8'd3, 8'hFE, 8'h80, 8'd127), ap(8'd10, 8'd5), 1'b1, 1'b0);
    idle(3);

    // Accumulation across interleaved zero beats, one of which carries last.
    beat(ones_w, ones_a, 1'b0, 1'b0);
    beat(ones_w, ones_a, 1'b1, 1'b1);
    beat(ones_w, ones_a, 1'b0, 1'b0);
    beat(ones_w, ones_a, 1'b0, 1'b1);
    beat(ones_w, ones_a, 1'b0, 1'b0);
    beat(ones_w, ones_a, 1'b1, 1'b0);
    idle(3);

    // Stall while vld=1 and a partial sum is in the pipeline.
    beat(ones_w, ones_a, 1'b0, 1'b0);
    beat(ones_w, ones_a, 1'b0, 1'b0);
    beat(ones_w, ones_a, 1'b1, 1'b0);
    beat(wp(8'd2, 8'd2, 8'd2, 8'd2), ap(8'd3, 8'd3), 1'b0, 1'b0);
    beat(wp(8'd2, 8'd2, 8'd2, 8'd2), ap(8'd3, 8'd3), 1'b0, 1'b0);
    stall(5);
    beat(wp(8'd2, 8'd2, 8'd2, 8'd2), ap(8'd3, 8'd3), 1'b1, 1'b0);
    idle(3);

    // Back-to-back last beats with all-ones activations.
    for (int i = 0; i < 3; i++) begin
      beat(wp(8'd1, 8'd1, 8'd2, 8'hFD), ap(8'd255, 8'd255), 1'b1, 1'b0);
    end
    idle(3);

    // Large products that overflow the 8-bit accumulator.
    beat(wp(8'd127, 8'd127, 8'd127, 8'd127), ap(8'd255, 8'd255), 1'b0, 1'b0);
    beat(wp(8'd127, 8'd127, 8'd127, 8'd127), ap(8'd255, 8'd255), 1'b1, 1'b0);
    idle(3);

    // Random traffic with random enable gaps.
    for (int i = 0; i < 60; i++) begin
      rst  = 1'b0;
      en   = ($urandom_range(0, 3) != 0);
      w    = $urandom;
      a    = 16'($urandom);
      last = ($urandom_range(0, 2) == 0);
      zero = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle(4);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
